// File: rtl/exec_task_scheduler.sv
`default_nettype none
// ============================================================================
// exec_task_scheduler -- routes tasks by cluster id into per-cluster FIFOs and
// runs one start/done handshake per cluster. Optional: SCHED_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
module exec_task_scheduler #(
   parameter int CLUSTER_NUM    = 7,
   parameter int FIFO_DEPTH     = 4,
   parameter int TASK_BW        = 72,
   parameter int TASK_REDUCE_BW = 68
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                task_valid,
   output logic                                task_ready,
   input  logic [TASK_BW-1:0]                  task_in,
   output logic [CLUSTER_NUM-1:0]              exec_start,
   output logic [CLUSTER_NUM*TASK_REDUCE_BW-1:0] exec_task,
   input  logic [CLUSTER_NUM-1:0]              exec_done,
   output logic [CLUSTER_NUM-1:0]              cluster_busy,
   output logic                                all_idle,
   output logic                                err_bad_id,
   input  logic                                err_clr
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [CLUSTER_NUM*16-1:0]           perf_done_cnt,
   input  logic                                perf_clr
`endif
);
   localparam int IDW = TASK_BW - TASK_REDUCE_BW;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int IDN = 1 << IDW;
   localparam logic [IDW:0] C_NUM = (IDW+1)'(CLUSTER_NUM);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   logic [IDW-1:0]            task_id;
   logic [TASK_REDUCE_BW-1:0] task_body;
   logic                      bad_id;
   logic                      accept;
   logic                      ready_en;
   logic [IDN-1:0]            full_by_id;
   logic [CLUSTER_NUM-1:0]    cl_idle;

   assign task_id    = task_in[TASK_BW-1:TASK_REDUCE_BW];
   assign task_body  = task_in[TASK_REDUCE_BW-1:0];
   assign bad_id     = ({1'b0, task_id} >= C_NUM);
   // Bad ids are always accepted so they can be dropped and flagged.
   assign task_ready = ready_en & (bad_id | ~full_by_id[task_id]);
   assign accept     = task_valid & task_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en   <= 1'b0;
         all_idle   <= 1'b1;
         err_bad_id <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         all_idle <= &cl_idle;
         if (accept && bad_id)
            err_bad_id <= 1'b1;
         else if (err_clr)
            err_bad_id <= 1'b0;
      end
   end

   for (genvar j = CLUSTER_NUM; j < IDN; j++) begin : g_pad
      assign full_by_id[j] = 1'b0;
   end

   for (genvar i = 0; i < CLUSTER_NUM; i++) begin : g_cluster
      state_t                    state, state_nxt;
      logic [PW-1:0]             wr_ptr, rd_ptr;
      logic [CW-1:0]             count;
      logic [TASK_REDUCE_BW-1:0] mem [FIFO_DEPTH];
      logic [TASK_REDUCE_BW-1:0] task_q;
      logic                      armed;
      logic                      push, pop, done_acc;

      assign push     = accept & ~bad_id & (task_id == IDW'(i));
      // armed is a registered "idle with work queued" view, giving the
      // two-edge gap from push or done to the start pulse.
      assign pop      = (state == S_IDLE) & armed;
      assign done_acc = (state == S_BUSY) & exec_done[i];

      assign full_by_id[i]   = (count == CW'(FIFO_DEPTH));
      assign cl_idle[i]      = (count == '0) & (state == S_IDLE);
      assign exec_start[i]   = (state == S_ISSUE);
      assign cluster_busy[i] = (state != S_IDLE);
      assign exec_task[i*TASK_REDUCE_BW +: TASK_REDUCE_BW] = task_q;

      always_comb begin
         state_nxt = state;
         case (state)
            S_IDLE:  if (pop) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_BUSY;
            S_BUSY:  if (exec_done[i]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            armed  <= 1'b0;
            task_q <= '0;
         end else begin
            state <= state_nxt;
            armed <= (state == S_IDLE) & (count != '0);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
               task_q <= mem[rd_ptr];
            end
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= task_body;
      end

`ifdef SCHED_PERF_CNT_EN
      logic [15:0] perf_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            perf_cnt <= '0;
         else if (perf_clr)
            perf_cnt <= '0;
         else if (done_acc && perf_cnt != 16'hFFFF)
            perf_cnt <= perf_cnt + 16'd1;
      end

      assign perf_done_cnt[i*16 +: 16] = perf_cnt;
`else
      logic unused_done_acc;
      assign unused_done_acc = done_acc;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_exec_task_scheduler.sv
`default_nettype none
// Testbench for exec_task_scheduler: directed vector table plus hand-written
// sequences for queueing, concurrency, bad ids, spurious done and reset.
module tb_exec_task_scheduler;
   localparam int N  = 7;
   localparam int RB = 68;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            task_valid;
   logic            task_ready;
   logic [71:0]     task_in;
   logic [N-1:0]    exec_start;
   logic [N*RB-1:0] exec_task;
   logic [N-1:0]    exec_done;
   logic [N-1:0]    cluster_busy;
   logic            all_idle;
   logic            err_bad_id;
   logic            err_clr;

   int errors = 0;
   int checks = 0;

   exec_task_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .task_valid   (task_valid),
      .task_ready   (task_ready),
      .task_in      (task_in),
      .exec_start   (exec_start),
      .exec_task    (exec_task),
      .exec_done    (exec_done),
      .cluster_busy (cluster_busy),
      .all_idle     (all_idle),
      .err_bad_id   (err_bad_id),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    id;
      logic [RB-1:0] data;
      logic [N-1:0]  exp_start;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [RB-1:0] slice(input int id);
      return exec_task[id*RB +: RB];
   endfunction

   task automatic push(input logic [3:0] id, input logic [RB-1:0] data);
      task_valid = 1'b1;
      task_in    = {id, data};
      tick();
      task_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [N-1:0] mask);
      exec_done = mask;
      tick();
      exec_done = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [RB-1:0] q0 [5];
      logic [RB-1:0] a1, a2, b1, b2;

      vecs[0] = '{4'd2, 68'h0_ABCDE,               7'b0000100};
      vecs[1] = '{4'd0, 68'hF_1234_5678_9ABC_DEF0, 7'b0000001};
      vecs[2] = '{4'd6, 68'hA_5555_AAAA_5555_AAAA, 7'b1000000};
      vecs[3] = '{4'd4, 68'h1,                     7'b0010000};

      rst_n = 1'b0; task_valid = 1'b0; task_in = '0; exec_done = '0; err_clr = 1'b0;
      tick(); tick();
      chk("rst_ready", task_ready, 0);
      chk("rst_idle", all_idle, 1);
      chk("rst_start", exec_start, 0);
      chk("rst_task", exec_task, 0);
      rst_n = 1'b1;
      #1 chk("rel_ready_pre", task_ready, 0);
      tick();
      chk("rel_ready", task_ready, 1);
      chk("rel_idle", all_idle, 1);
      chk("rel_start", exec_start, 0);
      chk("rel_err", err_bad_id, 0);
      chk("rel_busy", cluster_busy, 0);

      // Single-task round trips
      for (int v = 0; v < 4; v++) begin
         task_in = {vecs[v].id, vecs[v].data};
         #1 chk("rt_ready", task_ready, 1);
         push(vecs[v].id, vecs[v].data);
         chk("rt_start_k", exec_start, 0);
         tick();
         chk("rt_start_k1", exec_start, 0);
         tick();
         chk("rt_start_k2", exec_start, vecs[v].exp_start);
         chk("rt_task", slice(int'(vecs[v].id)), vecs[v].data);
         chk("rt_busy", cluster_busy, vecs[v].exp_start);
         tick();
         chk("rt_start_off", exec_start, 0);
         chk("rt_busy_hold", cluster_busy, vecs[v].exp_start);
         pulse_done(vecs[v].exp_start);
         chk("rt_busy_clr", cluster_busy, 0);
         chk("rt_idle_late", all_idle, 0);
         tick();
         chk("rt_idle", all_idle, 1);
      end

      // Queue depth on cluster 0
      for (int j = 0; j < 5; j++) q0[j] = 68'h100 + RB'(j * 17);
      for (int j = 0; j < 5; j++) begin
         task_in = {4'd0, q0[j]};
         #1 chk("q_ready", task_ready, 1);
         push(4'd0, q0[j]);
         if (j == 2) begin
            chk("q_start0", exec_start, 7'b0000001);
            chk("q_task0", slice(0), q0[0]);
         end
      end
      task_valid = 1'b1;
      task_in    = {4'd0, 68'hDEAD};
      #1 chk("q_full", task_ready, 0);
      tick();
      task_valid = 1'b0;
      for (int j = 1; j < 5; j++) begin
         pulse_done(7'b0000001);
         chk("q_start_m", exec_start, 0);
         tick();
         chk("q_start_m1", exec_start, 0);
         tick();
         chk("q_start_m2", exec_start, 7'b0000001);
         chk("q_order", slice(0), q0[j]);
         tick();
      end
      pulse_done(7'b0000001);
      tick();
      chk("q_idle", all_idle, 1);

      // Interleaved clusters 1 and 6
      a1 = 68'hA1; a2 = 68'hA2; b1 = 68'hB1; b2 = 68'hB2;
      push(4'd1, a1);
      push(4'd6, b1);
      push(4'd1, a2);
      push(4'd6, b2);
      chk("il_start6", exec_start, 7'b1000000);
      chk("il_busy", cluster_busy, 7'b1000010);
      chk("il_a1", slice(1), a1);
      chk("il_b1", slice(6), b1);
      tick();
      pulse_done(7'b1000000);
      tick(); tick();
      chk("il_start6b", exec_start, 7'b1000000);
      chk("il_b2", slice(6), b2);
      chk("il_a1_hold", slice(1), a1);
      pulse_done(7'b0000010);
      tick(); tick();
      chk("il_start1b", exec_start, 7'b0000010);
      chk("il_a2", slice(1), a2);
      chk("il_b2_hold", slice(6), b2);
      tick();
      pulse_done(7'b1000010);
      tick();
      chk("il_idle", all_idle, 1);

      // Bad id handling
      task_in = {4'd9, 68'h55};
      #1 chk("bad_ready", task_ready, 1);
      push(4'd9, 68'h55);
      chk("bad_err", err_bad_id, 1);
      tick(); tick();
      chk("bad_nostart", exec_start, 0);
      chk("bad_err_hold", err_bad_id, 1);
      chk("bad_idle", all_idle, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("bad_clr", err_bad_id, 0);
      push(4'd9, 68'h66);
      err_clr = 1'b1;
      push(4'd15, 68'h77);
      err_clr = 1'b0;
      chk("bad_set_wins", err_bad_id, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Spurious done while idle
      pulse_done(7'b0001000);
      chk("sp_busy", cluster_busy, 0);
      tick();
      chk("sp_start", exec_start, 0);
      chk("sp_idle", all_idle, 1);

      // Reset while cluster 3 busy with two queued
      push(4'd3, 68'h31);
      push(4'd3, 68'h32);
      push(4'd3, 68'h33);
      chk("mr_start", exec_start, 7'b0001000);
      tick();
      chk("mr_busy", cluster_busy, 7'b0001000);
      rst_n = 1'b0;
      #1;
      chk("mr_ready", task_ready, 0);
      chk("mr_busy0", cluster_busy, 0);
      chk("mr_start0", exec_start, 0);
      chk("mr_task0", exec_task, 0);
      chk("mr_idle", all_idle, 1);
      chk("mr_err", err_bad_id, 0);
      tick(); tick();
      rst_n = 1'b1;
      task_in = {4'd3, 68'h0};
      #1 chk("mr_ready_pre", task_ready, 0);
      tick();
      chk("mr_ready_rel", task_ready, 1);
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("mr_nostart", exec_start, 0);
      end
      chk("mr_idle_end", all_idle, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
